conv_window_gen: RTL and testbench

- Parametrised successor to the ping-pong/padding front-end; sits between the input stream buffer and the convolution engine.
- Converts a raster stream of C-channel pixels into 3x3xC windows.
- Adds run-time stride (1 or 2), optional zero padding, output back-pressure, end-of-frame marking and configuration checking.
- Internal storage is two line buffers.

---
 rtl/conv_window_pkg.sv | 31 +++
 rtl/cwg_line_buffer.sv | 31 +++
 rtl/conv_window_gen.sv | 199 +++++++++++++++++++
 tb/tb_conv_window_gen.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_window_pkg.sv
// rtl/conv_window_pkg.sv - shared types and constants for conv_window_gen
package conv_window_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } cwg_state_e;

   localparam int DEF_CHANNELS      = 8;
   localparam int DEF_DATA_WIDTH    = 8;
   localparam int DEF_MAX_IMG_WIDTH = 1024;
   localparam int DEF_DIM_W         = 16;

   localparam int PIX_W = DEF_CHANNELS * DEF_DATA_WIDTH;
   localparam int WIN_W = 9 * PIX_W;
   localparam int LB_AW = $clog2(DEF_MAX_IMG_WIDTH);

   // Window tap coordinates: ky=0 is the top row, kx=0 the left column
   localparam int KY_TOP   = 0;
   localparam int KY_MID   = 1;
   localparam int KY_BOT   = 2;
   localparam int KX_LEFT  = 0;
   localparam int KX_MID   = 1;
   localparam int KX_RIGHT = 2;

   function automatic logic [3:0] tap_idx(input int ky, input int kx);
      return 4'(3 * ky + kx);
   endfunction

endpackage

// File: rtl/cwg_line_buffer.sv
// rtl/cwg_line_buffer.sv - two stacked line buffers, async read, sync write
module cwg_line_buffer
   import conv_window_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int DEPTH = 1024,
   parameter int AW    = 10
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] row0_data,
   output logic [WIDTH-1:0] row1_data
);

   logic [WIDTH-1:0] row0_mem [DEPTH];
   logic [WIDTH-1:0] row1_mem [DEPTH];

   assign row0_data = row0_mem[addr];
   assign row1_data = row1_mem[addr];

   // Push the column down one row: older line moves to row1, new pixel lands in row0
   always_ff @(posedge clk) begin
      if (wr_en) begin
         row1_mem[addr] <= row0_mem[addr];
         row0_mem[addr] <= wr_data;
      end
   end

endmodule

// File: rtl/conv_window_gen.sv
// rtl/conv_window_gen.sv - raster pixel stream to 3x3xC convolution windows
module conv_window_gen
   import conv_window_pkg::*;
#(
   parameter int NUM_CHANNELS  = DEF_CHANNELS,
   parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
   parameter int MAX_IMG_WIDTH = DEF_MAX_IMG_WIDTH,
   parameter int DIM_W         = DEF_DIM_W
) (
   input  logic                                 sys_clk,
   input  logic                                 sys_rst,
   input  logic [DIM_W-1:0]                     cfg_width,
   input  logic [DIM_W-1:0]                     cfg_height,
   input  logic                                 cfg_pad_en,
   input  logic                                 cfg_stride2,
   input  logic                                 s_valid,
   input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]   s_data,
   output logic                                 s_ready,
   output logic                                 m_valid,
   output logic [9*NUM_CHANNELS*DATA_WIDTH-1:0] m_window,
   output logic                                 m_last,
   input  logic                                 m_ready,
   output logic                                 busy,
   output logic                                 cfg_err
);

   localparam int PW = NUM_CHANNELS * DATA_WIDTH;
   localparam int AW = (MAX_IMG_WIDTH > 1) ? $clog2(MAX_IMG_WIDTH) : 1;
   localparam logic [DIM_W-1:0] MAX_W = DIM_W'(MAX_IMG_WIDTH);
   localparam logic [DIM_W-1:0] ONE   = DIM_W'(1);
   localparam logic [DIM_W-1:0] TWO   = DIM_W'(2);
   localparam logic [DIM_W-1:0] THREE = DIM_W'(3);

   cwg_state_e         state_q, state_d;
   logic [DIM_W-1:0]   w_q, w_d, h_q, h_d, r_q, r_d, c_q, c_d;
   logic               pad_q, pad_d, s2_q, s2_d;
   logic [8:0][PW-1:0] win_q, win_d, m_window_q, m_window_d;
   logic               m_valid_q, m_valid_d, m_last_q, m_last_d;

   logic               cfg_ok, slot_real, virt_col, out_free, proc, wr_en;
   logic               row_end, col_end, emit, last_emit;
   logic [DIM_W-1:0]   r_max, c_max;
   logic [DIM_W:0]     r_reach, c_reach;
   logic [PW-1:0]      lb_row0, lb_row1, col_top, col_mid, col_bot;
   logic [8:0][PW-1:0] shifted, masked;

   cwg_line_buffer #(.WIDTH(PW), .DEPTH(MAX_IMG_WIDTH), .AW(AW)) u_line_buffer (
      .clk       (sys_clk),
      .wr_en     (wr_en),
      .addr      (c_q[AW-1:0]),
      .wr_data   (s_data),
      .row0_data (lb_row0),
      .row1_data (lb_row1)
   );

   // Slot position, handshake qualifiers and the emission decision for the current slot
   always_comb begin
      cfg_ok    = (cfg_width >= THREE) && (cfg_width <= MAX_W) && (cfg_height >= THREE);
      r_max     = pad_q ? h_q : h_q - ONE;
      c_max     = pad_q ? w_q : w_q - ONE;
      virt_col  = pad_q && (c_q == w_q);
      slot_real = !(pad_q && ((r_q == h_q) || (c_q == w_q)));
      row_end   = (r_q == r_max);
      col_end   = (c_q == c_max);
      out_free  = !m_valid_q || m_ready;
      proc      = (state_q == RUN) && out_free && (!slot_real || s_valid);
      wr_en     = proc && slot_real;
      // (r-1) is even exactly when r is odd, (r-2) exactly when r is even
      emit      = (pad_q ? (r_q != '0) : (r_q >= TWO))
               && (pad_q ? (c_q != '0) : (c_q >= TWO))
               && (!s2_q || (r_q[0] == pad_q))
               && (!s2_q || (c_q[0] == pad_q));
      // The last window is the emitting slot with no further emitting row or column after it
      r_reach   = {1'b0, r_q} + {{DIM_W{1'b0}}, 1'b1} + {{DIM_W{1'b0}}, s2_q};
      c_reach   = {1'b0, c_q} + {{DIM_W{1'b0}}, 1'b1} + {{DIM_W{1'b0}}, s2_q};
      last_emit = emit && (r_reach > {1'b0, r_max}) && (c_reach > {1'b0, c_max});
   end

   // Shift the incoming column into the 3x3 register and zero the taps that fall in the border
   always_comb begin
      col_top = virt_col ? '0 : lb_row1;
      col_mid = virt_col ? '0 : lb_row0;
      col_bot = slot_real ? s_data : '0;
      shifted = '0;
      for (int ky = 0; ky < 3; ky++) begin
         shifted[tap_idx(ky, KX_LEFT)] = win_q[tap_idx(ky, KX_MID)];
         shifted[tap_idx(ky, KX_MID)]  = win_q[tap_idx(ky, KX_RIGHT)];
      end
      shifted[tap_idx(KY_TOP, KX_RIGHT)] = col_top;
      shifted[tap_idx(KY_MID, KX_RIGHT)] = col_mid;
      shifted[tap_idx(KY_BOT, KX_RIGHT)] = col_bot;
      masked = shifted;
      if (pad_q) begin
         for (int ky = 0; ky < 3; ky++) begin
            for (int kx = 0; kx < 3; kx++) begin
               if (((ky == KY_TOP) && (r_q < TWO)) || ((ky == KY_MID) && (r_q == '0)) ||
                   ((kx == KX_LEFT) && (c_q < TWO)) || ((kx == KX_MID) && (c_q == '0))) begin
                  masked[tap_idx(ky, kx)] = '0;
               end
            end
         end
      end
   end

   // Frame FSM, slot counters and the output register
   always_comb begin
      state_d    = state_q;
      w_d        = w_q;
      h_d        = h_q;
      pad_d      = pad_q;
      s2_d       = s2_q;
      r_d        = r_q;
      c_d        = c_q;
      win_d      = win_q;
      m_valid_d  = m_valid_q;
      m_window_d = m_window_q;
      m_last_d   = m_last_q;

      if (m_valid_q && m_ready) begin
         m_valid_d = 1'b0;
         m_last_d  = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (cfg_ok) begin
               w_d     = cfg_width;
               h_d     = cfg_height;
               pad_d   = cfg_pad_en;
               s2_d    = cfg_stride2;
               r_d     = '0;
               c_d     = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (proc) begin
               win_d = shifted;
               if (emit) begin
                  m_valid_d  = 1'b1;
                  m_window_d = masked;
                  m_last_d   = last_emit;
               end
               if (row_end && col_end) begin
                  state_d = DONE;
               end else if (col_end) begin
                  c_d = '0;
                  r_d = r_q + ONE;
               end else begin
                  c_d = c_q + ONE;
               end
            end
         end
         DONE: begin
            if (out_free) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register; a reset abandons any frame in flight
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q    <= IDLE;
         w_q        <= '0;
         h_q        <= '0;
         pad_q      <= 1'b0;
         s2_q       <= 1'b0;
         r_q        <= '0;
         c_q        <= '0;
         win_q      <= '0;
         m_valid_q  <= 1'b0;
         m_window_q <= '0;
         m_last_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         w_q        <= w_d;
         h_q        <= h_d;
         pad_q      <= pad_d;
         s2_q       <= s2_d;
         r_q        <= r_d;
         c_q        <= c_d;
         win_q      <= win_d;
         m_valid_q  <= m_valid_d;
         m_window_q <= m_window_d;
         m_last_q   <= m_last_d;
      end
   end

   assign s_ready  = (state_q == RUN) && slot_real && out_free;
   assign m_valid  = m_valid_q;
   assign m_window = m_window_q;
   assign m_last   = m_last_q;
   assign busy     = (state_q != IDLE);
   assign cfg_err  = (state_q == IDLE) && !cfg_ok;

endmodule

// File: tb/tb_conv_window_gen.sv
// tb/tb_conv_window_gen.sv - scoreboard bench for conv_window_gen
module tb_conv_window_gen;

   localparam int C     = 8;
   localparam int DW    = 8;
   localparam int MAXW  = 1024;
   localparam int DIM_W = 16;
   localparam int PIX_W = C * DW;
   localparam int WIN_W = 9 * PIX_W;

   typedef struct packed {
      logic             last;
      logic [WIN_W-1:0] win;
   } exp_t;

   logic             sys_clk = 1'b0;
   logic             sys_rst;
   logic [DIM_W-1:0] cfg_width, cfg_height;
   logic             cfg_pad_en, cfg_stride2;
   logic             s_valid, s_ready;
   logic [PIX_W-1:0] s_data;
   logic             m_valid, m_last, m_ready;
   logic [WIN_W-1:0] m_window;
   logic             busy, cfg_err;

   exp_t exp_q[$];
   int   vectors     = 0;
   int   miscompares = 0;
   int   rcv_count   = 0;
   int   exp_total   = 0;
   int   rdy_mode    = 0;
   bit   stuck       = 1'b0;

   conv_window_gen #(
      .NUM_CHANNELS (C),
      .DATA_WIDTH   (DW),
      .MAX_IMG_WIDTH(MAXW),
      .DIM_W        (DIM_W)
   ) dut (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .cfg_width  (cfg_width),
      .cfg_height (cfg_height),
      .cfg_pad_en (cfg_pad_en),
      .cfg_stride2(cfg_stride2),
      .s_valid    (s_valid),
      .s_data     (s_data),
      .s_ready    (s_ready),
      .m_valid    (m_valid),
      .m_window   (m_window),
      .m_last     (m_last),
      .m_ready    (m_ready),
      .busy       (busy),
      .cfg_err    (cfg_err)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string tag, input logic [WIN_W-1:0] obs, input logic [WIN_W-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [PIX_W-1:0] pix(input int r, input int c, input int mode);
      logic [PIX_W-1:0] p;
      logic [7:0]       b;
      p = '0;
      for (int ch = 0; ch < C; ch++) begin
         if (mode == 0) b = 8'(16 * r + c);
         else if (ch == 0) b = 8'(c);
         else if (ch == 1) b = 8'(c >> 8);
         else if (ch == 2) b = 8'(r);
         else b = 8'(3 * r + c + ch);
         p[ch*DW +: DW] = b;
      end
      return p;
   endfunction

   // Reference: enumerate window centres directly and read taps from the image, zero outside it
   function automatic void build(input int w, input int h, input int pad, input int s, input int mode);
      int   ys[$];
      int   xs[$];
      int   rr, cc;
      exp_t e;
      if (pad != 0) begin
         for (int y = 0; y < h; y += s) ys.push_back(y);
         for (int x = 0; x < w; x += s) xs.push_back(x);
      end else begin
         for (int y = 1; y <= h - 2; y += s) ys.push_back(y);
         for (int x = 1; x <= w - 2; x += s) xs.push_back(x);
      end
      foreach (ys[i]) begin
         foreach (xs[j]) begin
            e.win = '0;
            for (int ky = 0; ky < 3; ky++) begin
               for (int kx = 0; kx < 3; kx++) begin
                  rr = ys[i] - 1 + ky;
                  cc = xs[j] - 1 + kx;
                  if (rr >= 0 && rr < h && cc >= 0 && cc < w)
                     e.win[(3*ky+kx)*PIX_W +: PIX_W] = pix(rr, cc, mode);
               end
            end
            e.last = (i == ys.size() - 1) && (j == xs.size() - 1);
            exp_q.push_back(e);
         end
      end
   endfunction

   function automatic int win_count(input int w, input int h, input int pad, input int s);
      if (pad != 0) return ((h + s - 1) / s) * ((w + s - 1) / s);
      return ((h - 3) / s + 1) * ((w - 3) / s + 1);
   endfunction

   // Called on a negedge while the block is IDLE; config is withdrawn once it has been latched
   task automatic begin_frame(input int w, input int h, input int pad, input int s, input int mode);
      build(w, h, pad, s, mode);
      exp_total   = win_count(w, h, pad, s);
      rcv_count   = 0;
      stuck       = 1'b0;
      cfg_width   = DIM_W'(w);
      cfg_height  = DIM_W'(h);
      cfg_pad_en  = (pad != 0);
      cfg_stride2 = (s == 2);
      #1;
      chk_int("cfg_err_valid_cfg", int'(cfg_err), 0);
      @(negedge sys_clk);
      cfg_width = '0;
   endtask

   task automatic send_pixels(input int w, input int mode, input int npix);
      int n;
      for (int i = 0; i < npix; i++) begin
         if (!stuck) begin
            s_valid = 1'b1;
            s_data  = pix(i / w, i % w, mode);
            n = 0;
            #3;
            while (!s_ready && n < 200) begin
               @(negedge sys_clk);
               #3;
               n++;
            end
            if (n >= 200) stuck = 1'b1;
            @(negedge sys_clk);
         end
      end
      s_valid = 1'b0;
   endtask

   task automatic finish_frame(input string tag);
      int n;
      n = 0;
      forever begin
         #3;
         if ((exp_q.size() == 0 && busy === 1'b0) || n >= 6000) break;
         @(negedge sys_clk);
         n++;
      end
      chk_int({tag, "_done_in_time"}, int'(n < 6000), 1);
      chk_int({tag, "_input_accepted"}, int'(stuck), 0);
      chk_int({tag, "_window_count"}, rcv_count, exp_total);
      @(negedge sys_clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk_int({tag, "_m_valid"}, int'(m_valid), 0);
      chk_int({tag, "_m_last"}, int'(m_last), 0);
      chk_int({tag, "_s_ready"}, int'(s_ready), 0);
      chk_int({tag, "_busy"}, int'(busy), 0);
      chk_int({tag, "_cfg_err"}, int'(cfg_err), 0);
      chk({tag, "_m_window"}, m_window, '0);
   endtask

   // Output side: drive m_ready, pop the scoreboard on each handshake, watch stall behaviour
   initial begin
      exp_t                e;
      logic                prev_stall;
      logic [WIN_W-1:0]    held_win;
      logic                held_last;
      m_ready    = 1'b1;
      prev_stall = 1'b0;
      held_win   = '0;
      held_last  = 1'b0;
      forever begin
         @(negedge sys_clk);
         m_ready = (rdy_mode == 1) ? !m_ready : 1'b1;
         #3;
         if (sys_rst) begin
            prev_stall = 1'b0;
            continue;
         end
         if (prev_stall) begin
            chk("stall_window_held", m_window, held_win);
            chk_int("stall_last_held", int'(m_last), int'(held_last));
            chk_int("stall_valid_held", int'(m_valid), 1);
         end
         if (m_valid && !m_ready) chk_int("s_ready_during_stall", int'(s_ready), 0);
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               chk_int("unexpected_window", int'(m_valid), 0);
            end else begin
               e = exp_q.pop_front();
               chk("window", m_window, e.win);
               chk_int("window_last", int'(m_last), int'(e.last));
            end
            rcv_count++;
         end
         prev_stall = m_valid && !m_ready;
         held_win   = m_window;
         held_last  = m_last;
      end
   end

   initial begin
      sys_rst     = 1'b1;
      cfg_width   = 16'd4;
      cfg_height  = 16'd4;
      cfg_pad_en  = 1'b1;
      cfg_stride2 = 1'b0;
      s_valid     = 1'b0;
      s_data      = '0;
      @(negedge sys_clk);
      #3;
      check_reset_outputs("reset");
      @(negedge sys_clk);
      @(negedge sys_clk);

      // 4x4 padded, stride 1
      sys_rst = 1'b0;
      begin_frame(4, 4, 1, 1, 0);
      send_pixels(4, 0, 16);
      finish_frame("pad_4x4_s1");

      // 5x5 unpadded, stride 2
      begin_frame(5, 5, 0, 2, 0);
      send_pixels(5, 0, 25);
      finish_frame("nopad_5x5_s2");

      // 4x4 padded with downstream stalling every other cycle
      rdy_mode = 1;
      begin_frame(4, 4, 1, 1, 0);
      send_pixels(4, 0, 16);
      finish_frame("pad_4x4_stall");

      // Even dimensions with stride 2, where the final slots do not emit
      begin_frame(6, 4, 1, 2, 0);
      send_pixels(6, 0, 24);
      finish_frame("pad_6x4_s2_stall");
      begin_frame(6, 6, 0, 2, 0);
      send_pixels(6, 0, 36);
      finish_frame("nopad_6x6_s2_stall");
      rdy_mode = 0;
      begin_frame(7, 5, 0, 1, 0);
      send_pixels(7, 0, 35);
      finish_frame("nopad_7x5_s1");

      // Invalid configurations hold the block in IDLE
      cfg_width  = 16'd2;
      cfg_height = 16'd4;
      cfg_pad_en = 1'b1;
      s_valid    = 1'b1;
      s_data     = pix(0, 0, 0);
      #3;
      chk_int("cfg_err_w2", int'(cfg_err), 1);
      chk_int("s_ready_w2", int'(s_ready), 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge sys_clk);
         #3;
         chk_int("busy_w2", int'(busy), 0);
         chk_int("m_valid_w2", int'(m_valid), 0);
      end
      @(negedge sys_clk);
      cfg_width  = 16'd4;
      cfg_height = 16'd1;
      #3;
      chk_int("cfg_err_h1", int'(cfg_err), 1);
      chk_int("s_ready_h1", int'(s_ready), 0);
      @(negedge sys_clk);
      #3;
      chk_int("busy_h1", int'(busy), 0);
      s_valid = 1'b0;
      @(negedge sys_clk);
      begin_frame(4, 4, 1, 1, 0);
      send_pixels(4, 0, 16);
      finish_frame("after_cfg_fix");

      // Reset in the middle of a frame, then a clean frame
      begin_frame(4, 4, 1, 1, 0);
      send_pixels(4, 0, 7);
      sys_rst     = 1'b1;
      cfg_width   = 16'd4;
      cfg_height  = 16'd4;
      cfg_pad_en  = 1'b1;
      cfg_stride2 = 1'b0;
      #3;
      check_reset_outputs("midframe_reset");
      exp_q.delete();
      @(negedge sys_clk);
      sys_rst = 1'b0;
      begin_frame(4, 4, 1, 1, 0);
      send_pixels(4, 0, 16);
      finish_frame("after_reset");

      // Full-width line, padded, stride 2
      begin_frame(MAXW, 3, 1, 2, 1);
      send_pixels(MAXW, 1, MAXW * 3);
      finish_frame("max_width");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
